median_window_collector: RTL and testbench
==========================================

Name: median_window_collector

Overview:
- Consumer end of the 3x3 window coordinate stream. It takes the signed (xWindow, yWindow, windowOut) sample stream together with the pixel read back for each coordinate.
- Out-of-image coordinates are replaced by a pad value. Nine samples are collected, then sorted sequentially with an odd-even transposition network.
- Emits the median as a one-cycle valid pulse. Sits between the pixel memory read path and the filtered-image writer.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 64, image width in pixels; valid x is 0..IMG_W-1; max 127.
- IMG_H, 64, image height in pixels; valid y is 0..IMG_H-1; max 127.
- PAD_VALUE, 0, substituted pixel for out-of-bounds coordinates; DATA_W bits.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset: logic is reset on a rising clk edge where reset==0.
- xWindow  input  8  signed x coordinate of current window sample.
- yWindow  input  8  signed y coordinate of current window sample.
- windowOut  input  1  sample valid; xWindow, yWindow and pixIn are all qualified by it in the same cycle.
- pixIn  input  DATA_W  pixel read at (xWindow, yWindow); memory latency is already aligned upstream.
- medianOut  output  DATA_W  median of the last 9 collected samples.
- medianValid  output  1  one-cycle pulse; medianOut is valid while this is high.
- busy  output  1  high in COLLECT, SORT and EMIT states.
- overrun  output  1  one-cycle pulse when a sample arrives in SORT or EMIT and is dropped.

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE, sample count=0, pass count=0.
  - medianOut=0, medianValid=0, overrun=0. Buffer contents don't care.
  - Reset mid-COLLECT or mid-SORT abandons the window; no medianValid is produced for it.
- Bounds check: a sample is out-of-bounds if x<0, x>=IMG_W, y<0 or y>=IMG_H, using signed compare. An out-of-bounds sample stores PAD_VALUE; otherwise pixIn is stored.
- States:
  - IDLE: when windowOut=1, store the sample in buf[0], count=1, go to COLLECT.
  - COLLECT: when windowOut=1, store into buf[count] and increment count. Cycles with windowOut=0 hold all state; gaps of any length are legal. When the 9th sample is stored (edge E), go to SORT with pass=0.
  - SORT: one odd-even transposition pass per edge.
    - Even pass: compare-swap pairs (0,1), (2,3), (4,5), (6,7).
    - Odd pass: compare-swap pairs (1,2), (3,4), (5,6), (7,8).
    - Swap keeps the smaller value at the lower index; unsigned compare; equal values are not swapped.
    - Passes 0..8 execute on edges E+1..E+9. At E+9 go to EMIT.
  - EMIT: at edge E+10, medianOut<=buf[4], medianValid<=1, state<=IDLE. medianValid clears at E+11. medianOut holds until the next EMIT.
- Latency: medianValid rises 10 edges after the edge that captured the 9th sample.
- Throughput: a new first sample is accepted no earlier than edge E+11, i.e. while in IDLE.
- Simultaneous events: windowOut=1 in SORT or EMIT drops the sample, pulses overrun for one cycle, and leaves the buffer, count and state unaffected. Reset has priority over everything.
- Input ordering: sample order within the window is irrelevant to the result.

Optional Feature:
- Macro MEDIAN_MINMAX_EN.
- When defined:
  - Adds output ports minOut and maxOut, each DATA_W wide.
  - At the EMIT edge they load buf[0] and buf[8] respectively, qualified by medianValid. Both reset to 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- In-bounds window, center (10,10), pixIn sequence 9,8,7,6,5,4,3,2,1, no gaps: medianValid pulses exactly 10 edges after the 9th sample with medianOut=5, busy=0 afterwards. With MEDIAN_MINMAX_EN: minOut=1, maxOut=9.
- Corner window, center (0,0), all pixIn=200, PAD_VALUE=0: 5 samples are out-of-bounds, giving medianOut=0. Center (1,1): all in-bounds, giving medianOut=200.
- Far edge, center (63,63): samples with x=64 or y=64 are padded. pixIn=50, PAD_VALUE=255: 4 values of 50 and 5 of 255, giving medianOut=255.
- Gapped input: 9 samples 3,3,7,1,7,7,2,9,7 with windowOut low for 0-4 random cycles between them: medianOut=7, with latency counted from the 9th sample.
- Overrun: assert windowOut for 2 cycles during SORT: overrun pulses twice, the current median is unaffected, and the next window starting from IDLE gives the correct result.
- Reset mid-operation: drive reset=0 for one edge after 5 samples and again during SORT pass 4: no medianValid, outputs=0, state IDLE. A following full window gives the correct median.

Source files
------------

// File: rtl/median_window_collector.sv
// Collects a 3x3 window of pixels (padding out-of-image coordinates), sorts it with a
// sequential odd-even transposition network and emits the median. Define MEDIAN_MINMAX_EN to add minOut/maxOut.
module median_window_collector #(
    parameter int                DATA_W    = 8,
    parameter int                IMG_W     = 64,
    parameter int                IMG_H     = 64,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        xWindow,
    input  logic [7:0]        yWindow,
    input  logic              windowOut,
    input  logic [DATA_W-1:0] pixIn,
    output logic [DATA_W-1:0] medianOut,
    output logic              medianValid,
    output logic              busy,
    output logic              overrun
`ifdef MEDIAN_MINMAX_EN
    ,
    output logic [DATA_W-1:0] minOut,
    output logic [DATA_W-1:0] maxOut
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] SORT    = 2'd2;
    localparam logic [1:0] EMIT    = 2'd3;

    localparam logic signed [7:0] X_LIMIT = 8'(IMG_W);
    localparam logic signed [7:0] Y_LIMIT = 8'(IMG_H);
    localparam logic [3:0] LAST_SAMPLE = 4'd8;
    localparam logic [3:0] LAST_PASS   = 4'd8;

    logic [1:0]        state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic [3:0]        pass_q, pass_d;
    logic [DATA_W-1:0] sampleBuf_q [9];
    logic [DATA_W-1:0] sampleBuf_d [9];
    logic [DATA_W-1:0] medianOut_q, medianOut_d;
    logic              medianValid_q, medianValid_d;
    logic              overrun_q, overrun_d;
`ifdef MEDIAN_MINMAX_EN
    logic [DATA_W-1:0] minOut_q, minOut_d;
    logic [DATA_W-1:0] maxOut_q, maxOut_d;
`endif

    logic signed [7:0] xSigned;
    logic signed [7:0] ySigned;
    logic              outOfBounds;
    logic [DATA_W-1:0] sampleVal;
    logic [DATA_W-1:0] evenPass [9];
    logic [DATA_W-1:0] oddPass  [9];

    assign xSigned     = $signed(xWindow);
    assign ySigned     = $signed(yWindow);
    assign outOfBounds = (xSigned < 8'sd0) || (xSigned >= X_LIMIT) ||
                         (ySigned < 8'sd0) || (ySigned >= Y_LIMIT);
    assign sampleVal   = outOfBounds ? PAD_VALUE : pixIn;

    // Both pass flavours are built every cycle; the pass parity picks one.
    always_comb begin
        evenPass = sampleBuf_q;
        oddPass  = sampleBuf_q;
        for (int k = 0; k < 4; k++) begin
            if (sampleBuf_q[2*k] > sampleBuf_q[2*k+1]) begin
                evenPass[2*k]   = sampleBuf_q[2*k+1];
                evenPass[2*k+1] = sampleBuf_q[2*k];
            end
            if (sampleBuf_q[2*k+1] > sampleBuf_q[2*k+2]) begin
                oddPass[2*k+1] = sampleBuf_q[2*k+2];
                oddPass[2*k+2] = sampleBuf_q[2*k+1];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pass_d        = pass_q;
        sampleBuf_d   = sampleBuf_q;
        medianOut_d   = medianOut_q;
        medianValid_d = 1'b0;
        overrun_d     = 1'b0;
`ifdef MEDIAN_MINMAX_EN
        minOut_d      = minOut_q;
        maxOut_d      = maxOut_q;
`endif
        case (state_q)
            IDLE: begin
                if (windowOut) begin
                    sampleBuf_d[0] = sampleVal;
                    count_d        = 4'd1;
                    state_d        = COLLECT;
                end
            end
            COLLECT: begin
                if (windowOut) begin
                    for (int i = 0; i < 9; i++) begin
                        if (count_q == 4'(i)) begin
                            sampleBuf_d[i] = sampleVal;
                        end
                    end
                    count_d = count_q + 4'd1;
                    if (count_q == LAST_SAMPLE) begin
                        state_d = SORT;
                        pass_d  = 4'd0;
                    end
                end
            end
            SORT: begin
                overrun_d   = windowOut;
                sampleBuf_d = pass_q[0] ? oddPass : evenPass;
                pass_d      = pass_q + 4'd1;
                if (pass_q == LAST_PASS) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                overrun_d     = windowOut;
                medianOut_d   = sampleBuf_q[4];
                medianValid_d = 1'b1;
                state_d       = IDLE;
`ifdef MEDIAN_MINMAX_EN
                minOut_d      = sampleBuf_q[0];
                maxOut_d      = sampleBuf_q[8];
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            count_q       <= 4'd0;
            pass_q        <= 4'd0;
            medianOut_q   <= '0;
            medianValid_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef MEDIAN_MINMAX_EN
            minOut_q      <= '0;
            maxOut_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pass_q        <= pass_d;
            medianOut_q   <= medianOut_d;
            medianValid_q <= medianValid_d;
            overrun_q     <= overrun_d;
`ifdef MEDIAN_MINMAX_EN
            minOut_q      <= minOut_d;
            maxOut_q      <= maxOut_d;
`endif
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset term.
    always_ff @(posedge clk) begin
        sampleBuf_q <= sampleBuf_d;
    end

    assign medianOut   = medianOut_q;
    assign medianValid = medianValid_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != IDLE);
`ifdef MEDIAN_MINMAX_EN
    assign minOut      = minOut_q;
    assign maxOut      = maxOut_q;
`endif

endmodule

// File: tb/tb_median_window_collector.sv
// Directed bench for median_window_collector: two instances differing only in PAD_VALUE (0 and 255)
// share one stimulus stream; expected medians are hand-computed.
module tb_median_window_collector;

    logic       clk;
    logic       reset;
    logic [7:0] xWindow;
    logic [7:0] yWindow;
    logic       windowOut;
    logic [7:0] pixIn;

    logic [7:0] medianA, medianB;
    logic       validA, validB, busyA, busyB, overrunA, overrunB;
`ifdef MEDIAN_MINMAX_EN
    logic [7:0] minA, maxA, minB, maxB;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] pixVals [9];

    median_window_collector #(.DATA_W(8), .IMG_W(64), .IMG_H(64), .PAD_VALUE(8'd0)) dutA (
        .clk(clk), .reset(reset), .xWindow(xWindow), .yWindow(yWindow),
        .windowOut(windowOut), .pixIn(pixIn), .medianOut(medianA),
        .medianValid(validA), .busy(busyA), .overrun(overrunA)
`ifdef MEDIAN_MINMAX_EN
        , .minOut(minA), .maxOut(maxA)
`endif
    );

    median_window_collector #(.DATA_W(8), .IMG_W(64), .IMG_H(64), .PAD_VALUE(8'd255)) dutB (
        .clk(clk), .reset(reset), .xWindow(xWindow), .yWindow(yWindow),
        .windowOut(windowOut), .pixIn(pixIn), .medianOut(medianB),
        .medianValid(validB), .busy(busyB), .overrun(overrunB)
`ifdef MEDIAN_MINMAX_EN
        , .minOut(minB), .maxOut(maxB)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; the sample is captured by the next rising edge.
    task automatic applyStimulus(input int x, input int y, input logic [7:0] p);
        windowOut = 1'b1;
        xWindow   = 8'(x);
        yWindow   = 8'(y);
        pixIn     = p;
        @(negedge clk);
        windowOut = 1'b0;
    endtask

    task automatic sendWindow(input int cx, input int cy, input int maxGap);
        int k = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                applyStimulus(cx + dx, cy + dy, pixVals[k]);
                k++;
                if (k < 9 && maxGap > 0) begin
                    repeat ($urandom_range(0, maxGap)) @(negedge clk);
                end
            end
        end
    endtask

    function automatic logic pickValid(input int sel);
        return (sel != 0) ? validB : validA;
    endfunction

    // startLat is the number of falling edges already elapsed since the 9th sample was captured.
    task automatic waitMedian(input string tag, input int sel, input int startLat,
                              input logic [7:0] expMed, input logic [7:0] expMin, input logic [7:0] expMax);
        int lat = startLat;
        while (!pickValid(sel) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 10);
        checkOutput({tag, "_median"}, (sel != 0) ? medianB : medianA, expMed);
`ifdef MEDIAN_MINMAX_EN
        checkOutput({tag, "_min"}, (sel != 0) ? minB : minA, expMin);
        checkOutput({tag, "_max"}, (sel != 0) ? maxB : maxA, expMax);
`else
        if (expMin > expMax) $display("[TB] note %s min above max", tag);
`endif
        @(negedge clk);
        checkOutput({tag, "_pulse_end"}, pickValid(sel), 1'b0);
        checkOutput({tag, "_busy_after"}, (sel != 0) ? busyB : busyA, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_median"}, medianA, 0);
        checkOutput({tag, "_valid"}, validA, 0);
        checkOutput({tag, "_busy"}, busyA, 0);
        checkOutput({tag, "_overrun"}, overrunA, 0);
`ifdef MEDIAN_MINMAX_EN
        checkOutput({tag, "_min"}, minA, 0);
        checkOutput({tag, "_max"}, maxA, 0);
`endif
    endtask

    initial begin
        int validSeen;
        reset     = 1'b0;
        windowOut = 1'b0;
        xWindow   = '0;
        yWindow   = '0;
        pixIn     = '0;
        repeat (3) @(negedge clk);
        checkResetState("por");
        reset = 1'b1;
        @(negedge clk);

        pixVals = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        sendWindow(10, 10, 0);
        checkOutput("center_busy_sort", busyA, 1'b1);
        waitMedian("center", 0, 0, 8'd5, 8'd1, 8'd9);

        pixVals = '{default: 8'd200};
        sendWindow(0, 0, 0);
        waitMedian("corner00", 0, 0, 8'd0, 8'd0, 8'd200);
        sendWindow(1, 1, 0);
        waitMedian("corner11", 0, 0, 8'd200, 8'd200, 8'd200);

        pixVals = '{default: 8'd50};
        sendWindow(63, 63, 0);
        waitMedian("faredge_pad255", 1, 0, 8'd255, 8'd50, 8'd255);
        checkOutput("faredge_pad0_median", medianA, 0);

        pixVals = '{8'd3, 8'd3, 8'd7, 8'd1, 8'd7, 8'd7, 8'd2, 8'd9, 8'd7};
        sendWindow(30, 40, 4);
        waitMedian("gapped", 0, 0, 8'd7, 8'd1, 8'd9);

        pixVals = '{8'd90, 8'd10, 8'd80, 8'd20, 8'd70, 8'd30, 8'd60, 8'd40, 8'd50};
        sendWindow(20, 20, 0);
        windowOut = 1'b1;
        xWindow   = 8'd20;
        yWindow   = 8'd20;
        pixIn     = 8'd0;
        @(negedge clk);
        checkOutput("overrun_first", overrunA, 1'b1);
        @(negedge clk);
        checkOutput("overrun_second", overrunA, 1'b1);
        windowOut = 1'b0;
        @(negedge clk);
        checkOutput("overrun_cleared", overrunA, 1'b0);
        checkOutput("overrun_still_busy", busyA, 1'b1);
        waitMedian("overrun_window", 0, 3, 8'd50, 8'd10, 8'd90);
        pixVals = '{8'd5, 8'd15, 8'd25, 8'd35, 8'd45, 8'd55, 8'd65, 8'd75, 8'd85};
        sendWindow(5, 5, 1);
        waitMedian("after_overrun", 0, 0, 8'd45, 8'd5, 8'd85);

        pixVals = '{8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105, 8'd106, 8'd107, 8'd108};
        for (int i = 0; i < 5; i++) applyStimulus(10 + i, 10, pixVals[i]);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkResetState("rst_collect");

        sendWindow(12, 12, 0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkResetState("rst_sort");
        validSeen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (validA) validSeen++;
        end
        checkOutput("rst_sort_no_valid", validSeen, 0);

        pixVals = '{8'd3, 8'd3, 8'd7, 8'd1, 8'd7, 8'd7, 8'd2, 8'd9, 8'd7};
        sendWindow(40, 8, 0);
        waitMedian("after_reset", 0, 0, 8'd7, 8'd1, 8'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
